// File: rtl/seg_scan_if.sv
// Bundle between the segment decoders, the scan driver and the display pins.
// The master side supplies patterns and controls; the slave side drives the anodes and segments.
interface seg_scan_if;
    logic [6:0] seg0;
    logic [6:0] seg1;
    logic [6:0] seg2;
    logic [6:0] seg3;
    logic [3:0] dp_in;
    logic [3:0] blank;
    logic       load;
    logic       blink;
    logic [3:0] an;
    logic [6:0] sseg;
    logic       dp;
    logic       frame;

    modport master (
        output seg0, seg1, seg2, seg3, dp_in, blank, load, blink,
        input  an, sseg, dp, frame
    );

    modport slave (
        input  seg0, seg1, seg2, seg3, dp_in, blank, load, blink,
        output an, sseg, dp, frame
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with a frame-synchronised shadow buffer,
// inter-digit dead time, per-digit blanking, decimal points and whole-display blink.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int DEAD      = 4,
    parameter int BLINK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD);
    localparam logic [BW-1:0] BLK_MAX  = BW'(BLINK_DIV - 1);

    logic [CW-1:0]     cnt_r;
    logic [1:0]        d_r;
    logic [BW-1:0]     blink_cnt_r;
    logic              phase_r;
    logic [3:0][6:0]   sh_seg_r;
    logic [3:0]        sh_dp_r;
    logic [3:0]        sh_blank_r;
    logic [3:0][6:0]   act_seg_r;
    logic [3:0]        act_dp_r;
    logic [3:0]        act_blank_r;
    logic              pend_r;
    logic [3:0]        an_r;
    logic [6:0]        sseg_r;
    logic              dp_r;
    logic              frame_r;

    logic              slot0_s;
    logic              xfer_s;
    logic [3:0][6:0]   act_seg_s;
    logic [3:0]        act_dp_s;
    logic [3:0]        act_blank_s;
    logic [3:0]        an_s;
    logic [6:0]        sseg_s;
    logic              dp_s;

    // Next active set and next output pattern; the post-transfer set drives slot 0 so DEAD=0 shows fresh data.
    always_comb begin
        slot0_s     = (cnt_r == {CW{1'b0}}) && (d_r == 2'd0);
        xfer_s      = slot0_s && pend_r;
        act_seg_s   = act_seg_r;
        act_dp_s    = act_dp_r;
        act_blank_s = act_blank_r;
        an_s        = 4'b1111;
        sseg_s      = 7'h7F;
        dp_s        = 1'b1;
        if (xfer_s) begin
            act_seg_s   = sh_seg_r;
            act_dp_s    = sh_dp_r;
            act_blank_s = sh_blank_r;
        end else begin
            act_seg_s   = act_seg_r;
            act_dp_s    = act_dp_r;
            act_blank_s = act_blank_r;
        end
        if ((cnt_r >= DEAD_CNT) && !act_blank_s[d_r] && !(bus.blink && phase_r)) begin
            an_s   = ~(4'b0001 << d_r);
            sseg_s = act_seg_s[d_r];
            dp_s   = ~act_dp_s[d_r];
        end else begin
            an_s   = 4'b1111;
            sseg_s = 7'h7F;
            dp_s   = 1'b1;
        end
    end

    // Slot position, digit index and free-running blink phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= {CW{1'b0}};
            d_r         <= 2'd0;
            blink_cnt_r <= {BW{1'b0}};
            phase_r     <= 1'b0;
        end else begin
            if (cnt_r == CNT_MAX) begin
                cnt_r <= {CW{1'b0}};
                d_r   <= d_r + 2'd1;
            end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
            if (blink_cnt_r == BLK_MAX) begin
                blink_cnt_r <= {BW{1'b0}};
                phase_r     <= ~phase_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + {{(BW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Shadow capture on LOAD, frame-boundary transfer into the active set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_seg_r    <= {4{7'h7F}};
            sh_dp_r     <= 4'b0000;
            sh_blank_r  <= 4'b1111;
            act_seg_r   <= {4{7'h7F}};
            act_dp_r    <= 4'b0000;
            act_blank_r <= 4'b1111;
            pend_r      <= 1'b0;
        end else begin
            act_seg_r   <= act_seg_s;
            act_dp_r    <= act_dp_s;
            act_blank_r <= act_blank_s;
            if (bus.load) begin
                sh_seg_r   <= {bus.seg3, bus.seg2, bus.seg1, bus.seg0};
                sh_dp_r    <= bus.dp_in;
                sh_blank_r <= bus.blank;
                pend_r     <= 1'b1;
            end else if (xfer_s) begin
                pend_r     <= 1'b0;
            end else begin
                pend_r     <= pend_r;
            end
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_r    <= 4'b1111;
            sseg_r  <= 7'h7F;
            dp_r    <= 1'b1;
            frame_r <= 1'b0;
        end else begin
            an_r    <= an_s;
            sseg_r  <= sseg_s;
            dp_r    <= dp_s;
            frame_r <= slot0_s;
        end
    end

    assign bus.an    = an_r;
    assign bus.sseg  = sseg_r;
    assign bus.dp    = dp_r;
    assign bus.frame = frame_r;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed frame/tearing/blink/blank/reset scenarios plus random
// loads and blink toggling, checked every edge against an edge-numbered behavioural model.
module tb_seg_scan_driver;
    localparam int SD = 8;
    localparam int DD = 2;
    localparam int BD = 64;

    logic clk;
    logic rst_n;
    seg_scan_if bus ();

    seg_scan_driver #(.SCAN_DIV(SD), .DEAD(DD), .BLINK_DIV(BD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int e        = 0;

    logic [6:0] m_sh_seg  [4];
    logic [6:0] m_act_seg [4];
    logic [3:0] m_sh_dp, m_act_dp, m_sh_blank, m_act_blank;
    bit         m_pend;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%h exp=%h", tag, e, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh_seg[i]  = 7'h7F;
            m_act_seg[i] = 7'h7F;
        end
        m_sh_dp     = 4'b0000;
        m_act_dp    = 4'b0000;
        m_sh_blank  = 4'b1111;
        m_act_blank = 4'b1111;
        m_pend      = 1'b0;
    endtask

    task automatic set_data(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [3:0] dpi, input logic [3:0] bl);
        bus.seg0  = s0;
        bus.seg1  = s1;
        bus.seg2  = s2;
        bus.seg3  = s3;
        bus.dp_in = dpi;
        bus.blank = bl;
    endtask

    // One rising edge: update the model from the edge number and inputs, then compare outputs.
    task automatic step(input bit ld);
        int  pos, slot, d;
        bit  ph, dark, blinked;
        logic [3:0] exp_an;
        bus.load = ld;
        @(posedge clk);
        e++;
        pos  = (e - 1) % SD;
        slot = (e - 1) / SD;
        d    = slot % 4;
        ph   = (((e - 1) / BD) % 2) == 1;
        if (pos == 0 && d == 0 && m_pend) begin
            for (int i = 0; i < 4; i++) m_act_seg[i] = m_sh_seg[i];
            m_act_dp    = m_sh_dp;
            m_act_blank = m_sh_blank;
            m_pend      = 1'b0;
        end
        if (ld) begin
            m_sh_seg[0] = bus.seg0;
            m_sh_seg[1] = bus.seg1;
            m_sh_seg[2] = bus.seg2;
            m_sh_seg[3] = bus.seg3;
            m_sh_dp     = bus.dp_in;
            m_sh_blank  = bus.blank;
            m_pend      = 1'b1;
        end
        dark    = (pos < DD) || m_act_blank[d];
        blinked = bus.blink && ph;
        exp_an  = (dark || blinked) ? 4'b1111 : ~(4'b0001 << d);
        #1;
        check_val("an", bus.an, exp_an);
        check_val("frame", bus.frame, (pos == 0 && d == 0) ? 1 : 0);
        if (!dark && !blinked) begin
            check_val("sseg", bus.sseg, m_act_seg[d]);
            check_val("dp", bus.dp, m_act_dp[d] ? 0 : 1);
        end else if (dark && !blinked) begin
            check_val("sseg_off", bus.sseg, 7'h7F);
            check_val("dp_off", bus.dp, 1);
        end else begin
            checks = checks;
        end
        bus.load = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (e < target) step(1'b0);
    endtask

    task automatic do_reset();
        set_data(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 4'b0000);
        bus.load  = 1'b0;
        bus.blink = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_an", bus.an, 4'b1111);
        check_val("rst_sseg", bus.sseg, 7'h7F);
        check_val("rst_dp", bus.dp, 1);
        check_val("rst_frame", bus.frame, 0);
        rst_n = 1'b1;
        e = 0;
    endtask

    // Loads the reference digit set at edge 5.
    task automatic load_at5(input logic [3:0] bl);
        run_to(4);
        set_data(7'h40, 7'h79, 7'h24, 7'h30, 4'b0100, bl);
        step(1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.load = 1'b0;
        bus.blink = 1'b0;
        set_data(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 4'b0000);

        // Reset scan without any load.
        do_reset();
        run_to(70);

        // Load, scan and tearing.
        do_reset();
        load_at5(4'b0000);
        run_to(35);
        check_val("load_an35", bus.an, 4'b1110);
        check_val("load_seg35", bus.sseg, 7'h40);
        run_to(44);
        set_data(7'h12, 7'h03, 7'h19, 7'h08, 4'b1000, 4'b0000);
        step(1'b1);
        run_to(51);
        check_val("load_an51", bus.an, 4'b1011);
        check_val("load_seg51", bus.sseg, 7'h24);
        check_val("load_dp51", bus.dp, 0);
        run_to(59);
        check_val("tear_old59", bus.sseg, 7'h30);
        run_to(67);
        check_val("tear_new67", bus.sseg, 7'h12);
        run_to(100);

        // LOAD coinciding with a transfer.
        do_reset();
        load_at5(4'b0000);
        run_to(32);
        set_data(7'h66, 7'h6D, 7'h7D, 7'h07, 4'b0001, 4'b0000);
        step(1'b1);
        run_to(35);
        check_val("sim_old35", bus.sseg, 7'h40);
        run_to(67);
        check_val("sim_new67", bus.sseg, 7'h66);
        check_val("sim_dp67", bus.dp, 0);
        run_to(80);

        // Blink across two blink half-periods.
        do_reset();
        bus.blink = 1'b1;
        load_at5(4'b0000);
        run_to(100);
        check_val("blink_off100", bus.an, 4'b1111);
        run_to(131);
        check_val("blink_on131", bus.an, 4'b1110);
        run_to(192);
        bus.blink = 1'b0;

        // Per-digit blank on digit 0.
        do_reset();
        load_at5(4'b0001);
        run_to(35);
        check_val("blank_an35", bus.an, 4'b1111);
        run_to(43);
        check_val("blank_an43", bus.an, 4'b1101);
        run_to(70);

        // Asynchronous reset half a cycle after a lit edge.
        do_reset();
        load_at5(4'b0000);
        run_to(36);
        #4;
        rst_n = 1'b0;
        #1;
        check_val("areset_an", bus.an, 4'b1111);
        check_val("areset_sseg", bus.sseg, 7'h7F);
        check_val("areset_dp", bus.dp, 1);

        // Random loads, data, blanking and blink toggling; also covers scan restart after reset.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            bit ld;
            ld = ($urandom_range(0, 15) == 0);
            if (ld) begin
                set_data(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom),
                         4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
            end
            if ($urandom_range(0, 39) == 0) bus.blink = ~bus.blink;
            step(ld);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
